// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame geometry, receiver states and the
// scancodes the input-controller consumers decode.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_DATA   = 4'b0010,
    ST_PARITY = 4'b0100,
    ST_STOP   = 4'b1000
  } ps2_state_e;

  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] ENTER     = 8'h5A;
  localparam logic [7:0] BACKSPACE = 8'h66;
  localparam logic [7:0] RELEASE   = 8'hF0;
  localparam logic [7:0] EXTENDED  = 8'hE0;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchroniser, agreement-count glitch
// filter and a registered falling-edge pulse on the filtered level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] agree_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync      <= '1;
      level     <= 1'b1;
      agree_cnt <= '0;
      fall      <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      // Level flips on the FILTER_LEN-th consecutive disagreeing sample.
      if (sync[1] != level) begin
        if (agree_cnt == CW'(FILTER_LEN - 1)) begin
          level     <= sync[1];
          agree_cnt <= '0;
          fall      <= level;
        end else begin
          agree_cnt <= agree_cnt + CW'(1);
        end
      end else begin
        agree_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks odd parity
// and stop bit, and strobes out each good scancode byte.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_level, clk_fall, dat_level, dat_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .Clock (Clock),
    .Reset (Reset),
    .line  (PS2_CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .Clock (Clock),
    .Reset (Reset),
    .line  (PS2_DAT),
    .level (dat_level),
    .fall  (dat_fall)
  );

  logic unused_lines;
  assign unused_lines = &{1'b0, clk_level, dat_fall};

  ps2_state_e    state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [7:0]    data_n;
  logic          data_en_n, parity_err_n, frame_err_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      data       <= '0;
      data_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      par        <= par_n;
      to_cnt     <= to_cnt_n;
      data       <= data_n;
      data_en    <= data_en_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    shift_n      = shift;
    bit_cnt_n    = bit_cnt;
    par_n        = par;
    data_n       = data;
    data_en_n    = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;

    if (state == ST_IDLE || clk_fall) to_cnt_n = '0;
    else                              to_cnt_n = to_cnt + TW'(1);

    unique case (state)
      ST_IDLE: begin
        if (clk_fall && !dat_level) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          shift_n   = {dat_level, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          par_n   = dat_level;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          state_n = ST_IDLE;
          if (!dat_level)                    frame_err_n = 1'b1;
          else if (odd_parity_ok(shift, par)) begin
            data_n    = shift;
            data_en_n = 1'b1;
          end else                           parity_err_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Expiry only when no edge arrives this cycle; an edge always wins.
    if (state != ST_IDLE && !clk_fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n     = ST_IDLE;
      shift_n     = '0;
      to_cnt_n    = '0;
      frame_err_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames at a 400-cycle bit period and
// checks strobes, held data, latencies and timeout against hand-derived values.
module tb_ps2_rx;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TOUT = 2000;
  localparam int unsigned HALF = 200;
  localparam int unsigned LAT  = FLEN + 3;
  localparam int unsigned NONE = 99;

  logic       Clock   = 1'b0;
  logic       Reset   = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] data;
  logic       data_en, parity_err, frame_err;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned cyc = 0, last_fall = 0;
  int unsigned n_en = 0, n_perr = 0, n_ferr = 0, n_multi = 0, n_hold = 0;
  int unsigned en_cyc = 0, ferr_cyc = 0;
  int unsigned b_en = 0, b_perr = 0, b_ferr = 0;
  logic [2:0]  prev_s = '0;

  ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .data       (data),
    .data_en    (data_en),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (data_en) begin
      n_en   <= n_en + 1;
      en_cyc <= cyc;
    end
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
    if ((({data_en, parity_err, frame_err}) & prev_s) != 3'b000) n_hold <= n_hold + 1;
    if ($countones({data_en, parity_err, frame_err}) > 1) n_multi <= n_multi + 1;
    prev_s <= {data_en, parity_err, frame_err};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic snap();
    b_en   = n_en;
    b_perr = n_perr;
    b_ferr = n_ferr;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      tick(50);
      PS2_CLK = 1'b0;
      tick(3);
      PS2_CLK = 1'b1;
      tick(HALF / 2 - 53);
    end else begin
      tick(HALF / 2);
    end
    PS2_DAT = b;
    tick(HALF / 2);
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int unsigned nbits, input int unsigned glitch_at);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
    tick(HALF);
  endtask

  initial begin
    tick(5);
    check("rst_data", data, 8'h00);
    check("rst_en", data_en, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    Reset = 1'b0;
    tick(20);
    check("idle_strobes", n_en + n_perr + n_ferr, 0);

    // 0x1C: three ones, parity 0
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, NONE);
    check("b1c_en", n_en - b_en, 1);
    check("b1c_data", data, 8'h1C);
    check("b1c_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);
    check("b1c_latency", en_cyc - last_fall, LAT);

    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11, NONE);
    check("bf0_en", n_en - b_en, 1);
    check("bf0_data", data, 8'hF0);
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 11, NONE);
    check("b5a_en", n_en - b_en, 1);
    check("b5a_data", data, 8'h5A);
    tick(500);
    check("b5a_hold", data, 8'h5A);

    // 0x16 has odd weight already, so parity 1 is wrong
    snap();
    send_frame(8'h16, 1'b1, 1'b1, 11, NONE);
    check("perr_cnt", n_perr - b_perr, 1);
    check("perr_no_en", n_en - b_en, 0);
    check("perr_data", data, 8'h5A);

    snap();
    send_frame(8'h45, 1'b0, 1'b0, 11, NONE);
    check("stop_ferr", n_ferr - b_ferr, 1);
    check("stop_no_en", n_en - b_en, 0);
    check("stop_data", data, 8'h5A);
    check("stop_latency", ferr_cyc - last_fall, LAT);

    // Partial frame then silence: timeout lands TOUT cycles after where the stop strobe would be
    snap();
    send_frame(8'h45, 1'b0, 1'b1, 5, NONE);
    tick(TOUT + 300);
    check("to_ferr", n_ferr - b_ferr, 1);
    check("to_time", ferr_cyc - last_fall, LAT + TOUT);
    check("to_no_en", n_en - b_en, 0);
    snap();
    send_frame(8'h45, 1'b0, 1'b1, 11, NONE);
    check("after_to_en", n_en - b_en, 1);
    check("after_to_data", data, 8'h45);

    snap();
    PS2_CLK = 1'b0;
    tick(3);
    PS2_CLK = 1'b1;
    tick(100);
    check("glitch_idle", (n_en - b_en) + (n_perr - b_perr) + (n_ferr - b_ferr), 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 4);
    check("glitch_en", n_en - b_en, 1);
    check("glitch_data", data, 8'h5A);
    check("glitch_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

    snap();
    send_frame(8'hAA, 1'b1, 1'b1, 5, NONE);
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(TOUT + 200);
    check("rst_mid_strobes", (n_en - b_en) + (n_perr - b_perr) + (n_ferr - b_ferr), 0);
    check("rst_mid_data", data, 8'h00);
    snap();
    send_frame(8'h26, 1'b0, 1'b1, 11, NONE);
    check("b26_en", n_en - b_en, 1);
    check("b26_data", data, 8'h26);

    check("strobe_overlap", n_multi, 0);
    check("strobe_held", n_hold, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
